// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//
// Groups the instruction-fetch bus signals that pass between the fetch
// sequencer and the rest of the pipeline.
//
// Signals:
//   imem_addr      : word address to the instruction memory (sequencer drives)
//   imem_data      : instruction word returned in the same cycle
//   stall          : hazard-unit hold request for the PC and IF/ID
//   redirect_valid : taken branch/jump; load redirect_pc and flush IF/ID
//   redirect_pc    : redirect target word address
//   id_valid       : IF/ID register holds a live instruction (sequencer drives)
//   id_instr       : IF/ID instruction (sequencer drives)
//   id_pc          : word address of id_instr (sequencer drives)
//
// Modports:
//   master : the fetch sequencer
//   slave  : memory, hazard unit, branch resolution and decode stage
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc;

    modport master (
        output imem_addr,
        output id_valid,
        output id_instr,
        output id_pc,
        input  imem_data,
        input  stall,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        output imem_data,
        output stall,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// PC sequencer and IF/ID stage controller. Drives the word address into a
// combinational instruction memory, registers the returned word into IF/ID,
// honours hazard stalls and branch redirects, and drains the pipeline once the
// last program word has been fetched.
//
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high reset
//   start   : single-cycle pulse; begins (IDLE) or restarts (DONE) fetch
//   bus     : fetch_sequencer_if.master (memory, stall, redirect, IF/ID)
//   busy    : registered, high in RUN or DRAIN
//   done    : registered, high in DONE
//   fetch_cnt, stall_cnt : performance counters (optional build only)
//
// Build option:
//   FETCH_PERF_CNT_EN : when defined, adds saturating fetch_cnt (RUN issues)
//                       and stall_cnt (RUN cycles stalled without redirect).
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned START_PC     = 0,
    parameter int unsigned END_PC       = 1157,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int          ADDR_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    fetch_sequencer_if.master  bus,
    output logic               busy,
    output logic               done
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_PC);
    localparam logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(END_PC);
    localparam logic [CNT_W-1:0]  DRAIN_INIT = CNT_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  drain_cnt;
    logic              id_valid_q;
    logic [31:0]       id_instr_q;
    logic [ADDR_W-1:0] id_pc_q;

    // A redirect beyond the program end leaves RUN without fetching anything.
    logic past_end;
    logic issue;
    logic start_ok;

    assign past_end = (pc > END_ADDR);
    assign issue    = (state == S_RUN) && !bus.redirect_valid && !past_end && !bus.stall;
    assign start_ok = ((state == S_IDLE) || (state == S_DONE)) && start;

    // The memory is combinational, so the address is simply the PC register.
    assign bus.imem_addr = pc;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc     = id_pc_q;

    // NOTE: every register in a clocked block is assigned with <= so all of
    // them update from the same pre-edge values; a blocking = here would let
    // later statements see half-updated state and break the simulation/
    // synthesis match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= START_ADDR;
            drain_cnt  <= '0;
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        pc    <= START_ADDR;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (bus.redirect_valid) begin
                        // Redirect beats stall: the wrong-path word is dropped.
                        pc         <= bus.redirect_pc;
                        id_valid_q <= 1'b0;
                        id_instr_q <= '0;
                    end else if (past_end) begin
                        state      <= S_DRAIN;
                        drain_cnt  <= DRAIN_INIT;
                        id_valid_q <= 1'b0;
                    end else if (!bus.stall) begin
                        id_instr_q <= bus.imem_data;
                        id_pc_q    <= pc;
                        id_valid_q <= 1'b1;
                        pc         <= pc + ADDR_W'(1);
                        if (pc == END_ADDR) begin
                            state     <= S_DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end
                    end
                end

                S_DRAIN: begin
                    if (bus.redirect_valid) begin
                        // Late branch out of the final block: resume fetching.
                        state      <= S_RUN;
                        pc         <= bus.redirect_pc;
                        id_valid_q <= 1'b0;
                        id_instr_q <= '0;
                    end else if (!bus.stall) begin
                        id_valid_q <= 1'b0;
                        // Counter is checked before decrementing so that DONE
                        // arrives DRAIN_CYCLES+1 cycles after the last fetch.
                        if (drain_cnt == '0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    pc         <= START_ADDR;
                    id_valid_q <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_hit;
    assign stall_hit = (state == S_RUN) && bus.stall && !bus.redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else if (start_ok) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue && (fetch_cnt != 32'hFFFF_FFFF)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall_hit && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    // Without the counters these decodes have no consumer.
    logic unused_decodes;
    assign unused_decodes = issue ^ start_ok;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed self-checking bench for fetch_sequencer with its default
// parameters (START_PC=0, END_PC=1157, DRAIN_CYCLES=4, ADDR_W=32). Inputs are
// driven and outputs sampled on the falling clock edge; the instruction memory
// is a combinational function of the address.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(32)) bus ();

    fetch_sequencer #(
        .START_PC     (0),
        .END_PC       (1157),
        .DRAIN_CYCLES (4),
        .ADDR_W       (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Memory image: every word with low nibble 5 is a NOP (all zero),
    // everything else carries its own address so lost/duplicated fetches show.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a[3:0] == 4'd5) ? 32'h0 : {16'hC0DE, a[15:0]};
    endfunction

    assign bus.imem_data = instr_of(bus.imem_addr);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_addr(input logic [31:0] a, input int budget);
        int n = 0;
        while (bus.imem_addr !== a && n < budget) begin
            tick();
            n++;
        end
        check("wait_addr", bus.imem_addr, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        start              = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tick();

        // Reset state
        check("rst_addr",     bus.imem_addr, 32'd0);
        check("rst_id_valid", bus.id_valid,  32'd0);
        check("rst_id_instr", bus.id_instr,  32'd0);
        check("rst_id_pc",    bus.id_pc,     32'd0);
        check("rst_busy",     busy,          32'd0);
        check("rst_done",     done,          32'd0);
        reset = 1'b0;

        // IDLE ignores stall and redirect
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd99;
        bus.stall          = 1'b1;
        tick();
        check("idle_addr", bus.imem_addr, 32'd0);
        check("idle_busy", busy,          32'd0);
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;

        // Start and steady fetch, id_pc one behind imem_addr
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy",  busy,          32'd1);
        check("start_addr",  bus.imem_addr, 32'd0);
        check("start_valid", bus.id_valid,  32'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("run_addr",  bus.imem_addr, k);
            check("run_id_pc", bus.id_pc,     k - 1);
            check("run_instr", bus.id_instr,  instr_of(k - 1));
            check("run_valid", bus.id_valid,  32'd1);
        end

        // Stall held 3 cycles at pc=7
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_addr",  bus.imem_addr, 32'd7);
            check("stall_id_pc", bus.id_pc,     32'd6);
        end
        bus.stall = 1'b0;
        tick();
        check("resume_addr",  bus.imem_addr, 32'd8);
        check("resume_id_pc", bus.id_pc,     32'd7);
        check("resume_instr", bus.id_instr,  instr_of(32'd7));
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt_3", stall_cnt, 32'd3);
`endif
        for (int k = 9; k <= 12; k++) begin
            tick();
            check("run2_addr", bus.imem_addr, k);
        end

        // Redirect wins over stall
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd24;
        tick();
        check("redir_addr",  bus.imem_addr, 32'd24);
        check("redir_valid", bus.id_valid,  32'd0);
        check("redir_instr", bus.id_instr,  32'd0);
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        tick();
        check("redir_id_pc",   bus.id_pc,     32'd24);
        check("redir_id_inst", bus.id_instr,  instr_of(32'd24));
        check("redir_valid2",  bus.id_valid,  32'd1);
        check("redir_addr2",   bus.imem_addr, 32'd25);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt_13", fetch_cnt, 32'd13);
        check("stall_cnt_hold", stall_cnt, 32'd3);
`endif

        // Reach the end, stall once in DRAIN, then late redirect to 87
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd1155;
        tick();
        bus.redirect_valid = 1'b0;
        check("end_redir", bus.imem_addr, 32'd1155);
        tick();
        tick();
        check("end_addr_1157", bus.imem_addr, 32'd1157);
        tick();
        check("last_addr",  bus.imem_addr, 32'd1158);
        check("last_id_pc", bus.id_pc,     32'd1157);
        check("last_valid", bus.id_valid,  32'd1);
        check("last_busy",  busy,          32'd1);
        bus.stall = 1'b1;
        tick();
        check("drain_stall_valid", bus.id_valid,  32'd1);
        check("drain_stall_addr",  bus.imem_addr, 32'd1158);
        bus.stall = 1'b0;
        tick();
        check("drain_valid", bus.id_valid, 32'd0);
        tick();
        check("drain_busy", busy, 32'd1);
        check("drain_done", done, 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd87;
        tick();
        bus.redirect_valid = 1'b0;
        check("late_addr",  bus.imem_addr, 32'd87);
        check("late_busy",  busy,          32'd1);
        check("late_done",  done,          32'd0);
        check("late_valid", bus.id_valid,  32'd0);
        tick();
        check("late_id_pc", bus.id_pc,     32'd87);
        check("late_addr2", bus.imem_addr, 32'd88);
        check("late_valid2", bus.id_valid, 32'd1);

        // Asynchronous reset mid-RUN at pc=500, with start held alongside
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd495;
        tick();
        bus.redirect_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("pre_reset_addr", bus.imem_addr, 32'd500);
        #2;
        reset = 1'b1;
        start = 1'b1;
        #1;
        check("async_addr",  bus.imem_addr, 32'd0);
        check("async_busy",  busy,          32'd0);
        check("async_valid", bus.id_valid,  32'd0);
        check("async_id_pc", bus.id_pc,     32'd0);
        check("async_instr", bus.id_instr,  32'd0);
        tick();
        check("reset_beats_start", busy, 32'd0);
        reset = 1'b0;
        start = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check("rst_fetch_cnt", fetch_cnt, 32'd0);
`endif

        // Full stall-free run and exact done timing
        start = 1'b1;
        tick();
        start = 1'b0;
        check("full_busy", busy,          32'd1);
        check("full_addr", bus.imem_addr, 32'd0);
        wait_addr(32'd1157, 1300);
        tick();
        check("full_last_addr", bus.imem_addr, 32'd1158);
        check("full_last_done", done,          32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("done_timing", done, (k == 5));
            check("busy_timing", busy, (k != 5));
        end
        check("done_valid", bus.id_valid,  32'd0);
        check("done_addr",  bus.imem_addr, 32'd1158);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt_full", fetch_cnt, 32'd1158);
        check("stall_cnt_full", stall_cnt, 32'd0);
`endif
        tick();
        check("done_hold",      done,          32'd1);
        check("done_hold_addr", bus.imem_addr, 32'd1158);

        // Restart from DONE, then redirect past the program end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", busy,          32'd1);
        check("restart_done", done,          32'd0);
        check("restart_addr", bus.imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("restart_fetch_cnt", fetch_cnt, 32'd0);
`endif
        tick();
        tick();
        check("restart_addr2", bus.imem_addr, 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd2000;
        tick();
        bus.redirect_valid = 1'b0;
        check("over_addr",  bus.imem_addr, 32'd2000);
        check("over_valid", bus.id_valid,  32'd0);
        check("over_busy",  busy,          32'd1);
        tick();
        check("over_drain_addr",  bus.imem_addr, 32'd2000);
        check("over_drain_valid", bus.id_valid,  32'd0);
        check("over_drain_busy",  busy,          32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("over_fetch_cnt", fetch_cnt, 32'd2);
`endif
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("over_done_timing", done, (k == 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
PC sequencer and IF/ID stage controller for the pipelined MIPS matrix-multiply core. It drives the word address into the combinational instruction memory and registers the returned instruction into the IF/ID pipeline register. It applies stalls from the hazard unit and redirects from branch resolution. On reaching the program end it drains the pipeline and flags completion.

Parameters:
START_PC, 0, first word address fetched after start (word-indexed; next PC = PC+1)
END_PC, 1157, last word address of the program; fetch of this word ends the program
DRAIN_CYCLES, 4, cycles spent in DRAIN so ID/EX/MEM/WB empty before done
ADDR_W, 32, PC/address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins or restarts program fetch
imem_addr  output  ADDR_W  word address to instruction memory; combinational from the PC register
imem_data  input  32  instruction word returned by memory in the same cycle
stall  input  1  hazard unit hold request; freezes the PC and IF/ID
redirect_valid  input  1  taken branch/jump; load redirect_pc and flush IF/ID
redirect_pc  input  ADDR_W  redirect target word address
id_valid  output  1  IF/ID register holds a live instruction
id_instr  output  32  IF/ID instruction
id_pc  output  ADDR_W  word address of id_instr
busy  output  1  high in RUN or DRAIN
done  output  1  high in DONE; program complete

Behaviour:
- Reset (async, immediate mid-operation): state=IDLE, pc=START_PC, id_valid=0, id_instr=0, id_pc=0, busy=0, done=0, drain counter=0. imem_addr therefore equals START_PC.
- imem_addr = pc at all times. There is no memory latency: imem_data is sampled on the same edge.
- States: IDLE, RUN, DRAIN, DONE. busy = (RUN|DRAIN), done = DONE. Both are registered state decodes.
- IDLE: start → RUN next cycle with pc=START_PC. All other inputs are ignored.
- RUN, per clock, in priority order:
  1. redirect_valid: pc←redirect_pc, id_valid←0, id_instr←0. This applies even if stall=1.
  2. stall: pc, id_valid, id_instr and id_pc hold.
  3. Otherwise: id_instr←imem_data, id_pc←pc, id_valid←1, pc←pc+1 (wraps modulo 2^ADDR_W).
  - If case 3 fires with pc==END_PC, the next state is DRAIN and drain counter←DRAIN_CYCLES.
  - If pc>END_PC while in RUN (for example after a redirect), the next state is DRAIN without issuing, and id_valid←0.
- DRAIN: the PC is frozen and no new fetch is issued.
  - If stall=1, the IF/ID register and the counter hold.
  - Otherwise id_valid←0 and the counter decrements.
  - redirect_valid → RUN at redirect_pc with IF/ID flushed; this covers a late branch out of the last block.
  - Counter reaching 0 with no redirect → DONE.
- DONE: id_valid=0 and the PC holds. start → RUN with pc=START_PC.
- start in RUN or DRAIN is ignored.
- Simultaneous start and reset: reset wins.
- Unwritten memory words are passed through unchanged. 32'h0 executes as a NOP (sll $0).
- DRAIN_CYCLES=0: go directly from the last fetch to DONE via a single DRAIN cycle with the counter already 0.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds output fetch_cnt (32): counts case-3 issues in RUN.
  - Adds output stall_cnt (32): counts RUN cycles with stall=1 and redirect_valid=0.
  - Both are cleared by reset and by an accepted start. Both saturate at 32'hFFFFFFFF and hold through DONE.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- reset, start at cycle 2, no stall/redirect → imem_addr 0,1,2,… one per cycle; id_pc lags imem_addr by 1; id_valid=1 from cycle 4; done rises exactly 1+DRAIN_CYCLES cycles after the fetch of word 1157.
- stall held 3 cycles while pc=7 → imem_addr stays 7 and id_pc stays 6 for 3 cycles; resumes at 8 with no duplicate and no lost instruction. With FETCH_PERF_CNT_EN, stall_cnt=3.
- redirect_valid with redirect_pc=24 while pc=12 and stall=1 → next cycle pc=24 and id_valid=0; following cycle id_pc=24, id_instr=imem[24].
- redirect to 87 during DRAIN (counter=2) → returns to RUN, busy stays 1, fetch resumes at 87, done stays 0.
- reset asserted mid-RUN at pc=500 → outputs reset immediately (asynchronously); start afterwards refetches from 0.
- In DONE, start pulse → busy=1 next cycle, pc=0. With FETCH_PERF_CNT_EN, fetch_cnt restarts from 0 (a stall-free full run ends with fetch_cnt=1158).
